// File: rtl/ahb_sram_arbiter.sv
// Two AHB-Lite slave ports sharing one single-port SRAM through a round-robin arbiter.
// Latency: two-cycle data phase (one wait state) per transfer; a losing port is held by HREADYOUT=0 until granted.
module ahb_sram_arbiter #(
   parameter int AW = 16
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          HSEL0,
   input  logic [31:0]   HADDR0,
   input  logic [1:0]    HTRANS0,
   input  logic          HWRITE0,
   input  logic [2:0]    HSIZE0,
   input  logic [31:0]   HWDATA0,
   input  logic          HREADY0,
   output logic          HREADYOUT0,
   output logic [31:0]   HRDATA0,
   output logic          HRESP0,
   input  logic          HSEL1,
   input  logic [31:0]   HADDR1,
   input  logic [1:0]    HTRANS1,
   input  logic          HWRITE1,
   input  logic [2:0]    HSIZE1,
   input  logic [31:0]   HWDATA1,
   input  logic          HREADY1,
   output logic          HREADYOUT1,
   output logic [31:0]   HRDATA1,
   output logic          HRESP1,
   output logic [AW-3:0] SRAMADDR,
   output logic [31:0]   SRAMWDATA,
   output logic [3:0]    SRAMWEN,
   output logic          SRAMCS,
   input  logic [31:0]   SRAMRDATA
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PEND,
      S_ACC,
      S_ERR1,
      S_ERR2
   } state_t;

   logic [1:0]    hsel;
   logic [1:0]    htrans_act;
   logic [1:0]    hwrite;
   logic [1:0]    hready;
   logic [AW-1:0] haddr  [2];
   logic [2:0]    hsize  [2];
   logic [31:0]   hwdata [2];
   logic [1:0]    accept;

   state_t        state_q [2];
   state_t        state_d [2];
   logic [AW-1:0] addr_q  [2];
   logic [AW-1:0] addr_d  [2];
   logic [2:0]    size_q  [2];
   logic [2:0]    size_d  [2];
   logic [1:0]    write_q;
   logic [1:0]    write_d;
   logic          rr_q;
   logic          rr_d;

   logic [1:0]    req;
   logic [1:0]    gnt;
   logic          gnt_idx;

   logic [1:0]    readyout;
   logic [1:0]    resp;
   logic [31:0]   rdata [2];

   logic          unused_bits;

   assign hsel       = {HSEL1, HSEL0};
   assign htrans_act = {HTRANS1[1], HTRANS0[1]};
   assign hwrite     = {HWRITE1, HWRITE0};
   assign hready     = {HREADY1, HREADY0};
   assign haddr[0]   = HADDR0[AW-1:0];
   assign haddr[1]   = HADDR1[AW-1:0];
   assign hsize[0]   = HSIZE0;
   assign hsize[1]   = HSIZE1;
   assign hwdata[0]  = HWDATA0;
   assign hwdata[1]  = HWDATA1;
   assign accept     = hsel & htrans_act & hready;

   assign unused_bits = ^{HADDR0[31:AW], HADDR1[31:AW], HTRANS0[0], HTRANS1[0]};

   function automatic logic is_illegal(input logic [2:0] size, input logic [1:0] a);
      is_illegal = (size > 3'd2) ||
                   (size == 3'd1 && a[0]) ||
                   (size == 3'd2 && a != 2'b00);
   endfunction

   function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] a);
      case (size)
         3'd0:    byte_mask = 4'b0001 << a;
         3'd1:    byte_mask = a[1] ? 4'b1100 : 4'b0011;
         default: byte_mask = 4'b1111;
      endcase
   endfunction

   // A granted port sits in ACC the next cycle, so it can never win twice in a row.
   always_comb begin
      req[0] = (state_q[0] == S_PEND);
      req[1] = (state_q[1] == S_PEND);
      gnt    = 2'b00;
      rr_d   = rr_q;
      if (req[0] && req[1]) begin
         gnt = rr_q ? 2'b10 : 2'b01;
      end else if (req[0]) begin
         gnt = 2'b01;
      end else if (req[1]) begin
         gnt = 2'b10;
      end
      if (gnt[0]) begin
         rr_d = 1'b1;
      end else if (gnt[1]) begin
         rr_d = 1'b0;
      end
   end

   assign gnt_idx = gnt[1];

   always_comb begin
      write_d = write_q;
      for (int p = 0; p < 2; p++) begin
         state_d[p] = state_q[p];
         addr_d[p]  = addr_q[p];
         size_d[p]  = size_q[p];
      end
      for (int p = 0; p < 2; p++) begin
         case (state_q[p])
            S_IDLE, S_ACC, S_ERR2: begin
               if (accept[p]) begin
                  addr_d[p]  = haddr[p];
                  size_d[p]  = hsize[p];
                  write_d[p] = hwrite[p];
                  state_d[p] = is_illegal(hsize[p], haddr[p][1:0]) ? S_ERR1 : S_PEND;
               end else begin
                  state_d[p] = S_IDLE;
               end
            end
            S_PEND: begin
               if (gnt[p]) begin
                  state_d[p] = S_ACC;
               end
            end
            S_ERR1:  state_d[p] = S_ERR2;
            default: state_d[p] = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int p = 0; p < 2; p++) begin
            state_q[p] <= S_IDLE;
            addr_q[p]  <= '0;
            size_q[p]  <= '0;
         end
         write_q <= '0;
         rr_q    <= 1'b0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            state_q[p] <= state_d[p];
            addr_q[p]  <= addr_d[p];
            size_q[p]  <= size_d[p];
         end
         write_q <= write_d;
         rr_q    <= rr_d;
      end
   end

   // Read data is only forwarded in ACC, which is exactly the cycle after the SRAM read.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         readyout[p] = 1'b1;
         resp[p]     = 1'b0;
         rdata[p]    = 32'h0;
         case (state_q[p])
            S_PEND: readyout[p] = 1'b0;
            S_ERR1: begin
               readyout[p] = 1'b0;
               resp[p]     = 1'b1;
            end
            S_ERR2: resp[p] = 1'b1;
            S_ACC: begin
               if (!write_q[p]) begin
                  rdata[p] = SRAMRDATA;
               end
            end
            default: ;
         endcase
      end
   end

   assign HREADYOUT0 = readyout[0];
   assign HREADYOUT1 = readyout[1];
   assign HRESP0     = resp[0];
   assign HRESP1     = resp[1];
   assign HRDATA0    = rdata[0];
   assign HRDATA1    = rdata[1];

   always_comb begin
      SRAMCS    = 1'b0;
      SRAMADDR  = '0;
      SRAMWDATA = 32'h0;
      SRAMWEN   = 4'b0000;
      if (gnt != 2'b00) begin
         SRAMCS    = 1'b1;
         SRAMADDR  = addr_q[gnt_idx][AW-1:2];
         SRAMWDATA = hwdata[gnt_idx];
         if (write_q[gnt_idx]) begin
            SRAMWEN = byte_mask(size_q[gnt_idx], addr_q[gnt_idx][1:0]);
         end
      end
   end

endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Directed bench for ahb_sram_arbiter: per-cycle vector table plus reset and contention sequences.
module tb_ahb_sram_arbiter;

   localparam int KI = 0;
   localparam int KR = 1;
   localparam int KW = 2;

   logic        HCLK;
   logic        HRESETn;
   logic        HSEL0, HWRITE0, HREADY0, HREADYOUT0, HRESP0;
   logic [31:0] HADDR0, HWDATA0, HRDATA0;
   logic [1:0]  HTRANS0;
   logic [2:0]  HSIZE0;
   logic        HSEL1, HWRITE1, HREADY1, HREADYOUT1, HRESP1;
   logic [31:0] HADDR1, HWDATA1, HRDATA1;
   logic [1:0]  HTRANS1;
   logic [2:0]  HSIZE1;
   logic [13:0] SRAMADDR;
   logic [31:0] SRAMWDATA;
   logic [3:0]  SRAMWEN;
   logic        SRAMCS;
   logic [31:0] SRAMRDATA;

   logic [31:0] mem [0:16383];
   int          n_pass;
   int          n_total;

   assign HREADY0 = HREADYOUT0;
   assign HREADY1 = HREADYOUT1;

   ahb_sram_arbiter #(.AW(16)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .HSEL0(HSEL0), .HADDR0(HADDR0), .HTRANS0(HTRANS0), .HWRITE0(HWRITE0),
      .HSIZE0(HSIZE0), .HWDATA0(HWDATA0), .HREADY0(HREADY0),
      .HREADYOUT0(HREADYOUT0), .HRDATA0(HRDATA0), .HRESP0(HRESP0),
      .HSEL1(HSEL1), .HADDR1(HADDR1), .HTRANS1(HTRANS1), .HWRITE1(HWRITE1),
      .HSIZE1(HSIZE1), .HWDATA1(HWDATA1), .HREADY1(HREADY1),
      .HREADYOUT1(HREADYOUT1), .HRDATA1(HRDATA1), .HRESP1(HRESP1),
      .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA), .SRAMWEN(SRAMWEN),
      .SRAMCS(SRAMCS), .SRAMRDATA(SRAMRDATA)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // Behavioural single-port SRAM: read data appears the cycle after a read select.
   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
   end
   always @(posedge HCLK) begin
      if (SRAMCS) begin
         if (SRAMWEN == 4'b0000) begin
            SRAMRDATA <= mem[SRAMADDR];
         end else begin
            for (int b = 0; b < 4; b++)
               if (SRAMWEN[b]) mem[SRAMADDR][8*b +: 8] = SRAMWDATA[8*b +: 8];
         end
      end
   end

   typedef struct {
      int          k0;
      logic [2:0]  z0;
      logic [31:0] a0;
      logic [31:0] d0;
      int          k1;
      logic [2:0]  z1;
      logic [31:0] a1;
      logic [31:0] d1;
      logic        e_cs;
      logic [3:0]  e_wen;
      logic [13:0] e_addr;
      logic [1:0]  e_rdy;
      logic [1:0]  e_resp;
      logic [31:0] e_rd0;
      logic [31:0] e_rd1;
   } vec_t;

   vec_t tbl [24];

   function automatic vec_t v(input int k0, input logic [2:0] z0, input logic [31:0] a0,
                              input logic [31:0] d0, input int k1, input logic [2:0] z1,
                              input logic [31:0] a1, input logic [31:0] d1, input logic cs,
                              input logic [3:0] wen, input logic [13:0] ad, input logic [1:0] rdy,
                              input logic [1:0] resp, input logic [31:0] rd0, input logic [31:0] rd1);
      vec_t r;
      r.k0 = k0; r.z0 = z0; r.a0 = a0; r.d0 = d0;
      r.k1 = k1; r.z1 = z1; r.a1 = a1; r.d1 = d1;
      r.e_cs = cs; r.e_wen = wen; r.e_addr = ad; r.e_rdy = rdy; r.e_resp = resp;
      r.e_rd0 = rd0; r.e_rd1 = rd1;
      return r;
   endfunction

   task automatic check(input string name, input logic ok, input string info);
      n_total++;
      if (ok === 1'b1) n_pass++;
      else $display("FAIL %s: %s", name, info);
   endtask

   task automatic drive_row(input vec_t r);
      HSEL0   = (r.k0 != KI);
      HTRANS0 = (r.k0 != KI) ? 2'b10 : 2'b00;
      HWRITE0 = (r.k0 == KW);
      HSIZE0  = r.z0;
      HADDR0  = r.a0;
      HWDATA0 = r.d0;
      HSEL1   = (r.k1 != KI);
      HTRANS1 = (r.k1 != KI) ? 2'b10 : 2'b00;
      HWRITE1 = (r.k1 == KW);
      HSIZE1  = r.z1;
      HADDR1  = r.a1;
      HWDATA1 = r.d1;
   endtask

   function automatic logic [31:0] beat_data(input int p, input int b);
      return 32'hC0DE0000 | (32'(p) << 8) | 32'(b);
   endfunction

   int          aph [2];
   int          dph [2];
   logic [31:0] base [2];
   logic [1:0]  rdy_s;

   task automatic drive_burst();
      HSEL0   = (aph[0] < 4);
      HTRANS0 = (aph[0] >= 4) ? 2'b00 : ((aph[0] == 0) ? 2'b10 : 2'b11);
      HWRITE0 = 1'b1;
      HSIZE0  = 3'd2;
      HADDR0  = base[0] + 32'(4 * aph[0]);
      HWDATA0 = (dph[0] >= 0) ? beat_data(0, dph[0]) : 32'h0;
      HSEL1   = (aph[1] < 4);
      HTRANS1 = (aph[1] >= 4) ? 2'b00 : ((aph[1] == 0) ? 2'b10 : 2'b11);
      HWRITE1 = 1'b1;
      HSIZE1  = 3'd2;
      HADDR1  = base[1] + 32'(4 * aph[1]);
      HWDATA1 = (dph[1] >= 0) ? beat_data(1, dph[1]) : 32'h0;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;

      // Simultaneous reads out of reset: port0 first, port1 one cycle later.
      tbl[0]  = v(KR, 2, 32'h0,   0, KR, 2, 32'h100, 0, 0, 4'h0, 14'h0,  2'b11, 2'b00, 0, 0);
      tbl[1]  = v(KI, 0, 0,       0, KI, 0, 0,       0, 1, 4'h0, 14'h0,  2'b00, 2'b00, 0, 0);
      tbl[2]  = v(KI, 0, 0,       0, KI, 0, 0,       0, 1, 4'h0, 14'h40, 2'b01, 2'b00, 0, 0);
      tbl[3]  = v(KI, 0, 0,       0, KI, 0, 0,       0, 0, 4'h0, 14'h0,  2'b11, 2'b00, 0, 0);
      // Port0 word write then read-back.
      tbl[4]  = v(KW, 2, 32'h10,  0,            KI, 0, 0, 0, 0, 4'h0, 14'h0, 2'b11, 2'b00, 0, 0);
      tbl[5]  = v(KI, 0, 0,       32'hDEADBEEF, KI, 0, 0, 0, 1, 4'hF, 14'h4, 2'b10, 2'b00, 0, 0);
      tbl[6]  = v(KR, 2, 32'h10,  32'hDEADBEEF, KI, 0, 0, 0, 0, 4'h0, 14'h0, 2'b11, 2'b00, 0, 0);
      tbl[7]  = v(KI, 0, 0,       0,            KI, 0, 0, 0, 1, 4'h0, 14'h4, 2'b10, 2'b00, 0, 0);
      tbl[8]  = v(KI, 0, 0,       0,            KI, 0, 0, 0, 0, 4'h0, 14'h0, 2'b11, 2'b00, 32'hDEADBEEF, 0);
      tbl[9]  = v(KI, 0, 0,       0,            KI, 0, 0, 0, 0, 4'h0, 14'h0, 2'b11, 2'b00, 0, 0);
      // Port1 byte and halfword writes, read back through port0.
      tbl[10] = v(KI, 0, 0, 0, KW, 0, 32'h3, 0,            0, 4'h0,    14'h0, 2'b11, 2'b00, 0, 0);
      tbl[11] = v(KI, 0, 0, 0, KI, 0, 0,     32'hAA000000, 1, 4'b1000, 14'h0, 2'b01, 2'b00, 0, 0);
      tbl[12] = v(KI, 0, 0, 0, KW, 1, 32'h6, 32'hAA000000, 0, 4'h0,    14'h0, 2'b11, 2'b00, 0, 0);
      tbl[13] = v(KI, 0, 0, 0, KI, 0, 0,     32'h5A5A0000, 1, 4'b1100, 14'h1, 2'b01, 2'b00, 0, 0);
      tbl[14] = v(KR, 2, 32'h0, 0, KI, 0, 0, 32'h5A5A0000, 0, 4'h0,    14'h0, 2'b11, 2'b00, 0, 0);
      tbl[15] = v(KI, 0, 0,     0, KI, 0, 0, 0,            1, 4'h0,    14'h0, 2'b10, 2'b00, 0, 0);
      tbl[16] = v(KR, 2, 32'h4, 0, KI, 0, 0, 0,            0, 4'h0,    14'h0, 2'b11, 2'b00, 32'hAA000000, 0);
      tbl[17] = v(KI, 0, 0,     0, KI, 0, 0, 0,            1, 4'h0,    14'h1, 2'b10, 2'b00, 0, 0);
      tbl[18] = v(KI, 0, 0,     0, KI, 0, 0, 0,            0, 4'h0,    14'h0, 2'b11, 2'b00, 32'h5A5A0000, 0);
      tbl[19] = v(KI, 0, 0,     0, KI, 0, 0, 0,            0, 4'h0,    14'h0, 2'b11, 2'b00, 0, 0);
      // Misaligned word on port0 and HSIZE=3 on port1: two-cycle ERROR, no SRAM access.
      tbl[20] = v(KW, 2, 32'h2, 0, KR, 3, 32'h0, 0, 0, 4'h0, 14'h0, 2'b11, 2'b00, 0, 0);
      tbl[21] = v(KI, 0, 0,     0, KI, 0, 0,     0, 0, 4'h0, 14'h0, 2'b00, 2'b11, 0, 0);
      tbl[22] = v(KI, 0, 0,     0, KI, 0, 0,     0, 0, 4'h0, 14'h0, 2'b11, 2'b11, 0, 0);
      tbl[23] = v(KI, 0, 0,     0, KI, 0, 0,     0, 0, 4'h0, 14'h0, 2'b11, 2'b00, 0, 0);

      HRESETn = 1'b0;
      drive_row(tbl[23]);
      #1;
      check("reset_state",
            HREADYOUT0 === 1'b1 && HREADYOUT1 === 1'b1 && HRESP0 === 1'b0 && HRESP1 === 1'b0 &&
            HRDATA0 === 32'h0 && HRDATA1 === 32'h0 && SRAMCS === 1'b0 && SRAMWEN === 4'h0 &&
            SRAMADDR === 14'h0 && SRAMWDATA === 32'h0,
            $sformatf("rdy=%b%b resp=%b%b cs=%b wen=%h addr=%h want rdy=11 resp=00 cs=0 wen=0 addr=0",
                      HREADYOUT1, HREADYOUT0, HRESP1, HRESP0, SRAMCS, SRAMWEN, SRAMADDR));
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;

      for (int i = 0; i < 24; i++) begin
         @(posedge HCLK);
         #1;
         drive_row(tbl[i]);
         @(negedge HCLK);
         check($sformatf("vec%0d", i),
               SRAMCS === tbl[i].e_cs && SRAMWEN === tbl[i].e_wen && SRAMADDR === tbl[i].e_addr &&
               {HREADYOUT1, HREADYOUT0} === tbl[i].e_rdy && {HRESP1, HRESP0} === tbl[i].e_resp &&
               HRDATA0 === tbl[i].e_rd0 && HRDATA1 === tbl[i].e_rd1,
               $sformatf("got cs=%b wen=%h addr=%h rdy=%b%b resp=%b%b rd0=%h rd1=%h want cs=%b wen=%h addr=%h rdy=%b resp=%b rd0=%h rd1=%h",
                         SRAMCS, SRAMWEN, SRAMADDR, HREADYOUT1, HREADYOUT0, HRESP1, HRESP0,
                         HRDATA0, HRDATA1, tbl[i].e_cs, tbl[i].e_wen, tbl[i].e_addr, tbl[i].e_rdy,
                         tbl[i].e_resp, tbl[i].e_rd0, tbl[i].e_rd1));
      end

      // Reset pulsed while port1 waits in PEND with its grant pending.
      @(posedge HCLK);
      #1;
      drive_row(v(KI, 0, 0, 0, KW, 2, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge HCLK);
      #1;
      drive_row(v(KI, 0, 0, 0, KI, 0, 0, 32'hBAD0BAD0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge HCLK);
      check("rst_pend", SRAMCS === 1'b1 && HREADYOUT1 === 1'b0,
            $sformatf("cs=%b rdy1=%b want cs=1 rdy1=0", SRAMCS, HREADYOUT1));
      #2;
      HRESETn = 1'b0;
      #1;
      check("rst_async",
            HREADYOUT1 === 1'b1 && HRESP1 === 1'b0 && SRAMCS === 1'b0 && SRAMWEN === 4'h0,
            $sformatf("rdy1=%b resp1=%b cs=%b wen=%h want rdy1=1 resp1=0 cs=0 wen=0",
                      HREADYOUT1, HRESP1, SRAMCS, SRAMWEN));
      @(posedge HCLK);
      @(posedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      check("rst_nowrite", mem[8] === 32'h0,
            $sformatf("mem[8]=%h want 00000000", mem[8]));
      @(negedge HCLK);
      check("rst_release_idle", SRAMCS === 1'b0 && HREADYOUT1 === 1'b1,
            $sformatf("cs=%b rdy1=%b want cs=0 rdy1=1", SRAMCS, HREADYOUT1));

      // Both ports run INCR4 word writes back to back from a fresh reset.
      base[0] = 32'h200;
      base[1] = 32'h300;
      for (int p = 0; p < 2; p++) begin
         aph[p] = 0;
         dph[p] = -1;
      end
      @(posedge HCLK);
      #1;
      drive_burst();
      for (int c = 0; c < 10; c++) begin
         @(negedge HCLK);
         rdy_s = {HREADYOUT1, HREADYOUT0};
         if (c >= 1 && c <= 8) begin
            int ep;
            int eb;
            logic [13:0] ea;
            ep = (c - 1) % 2;
            eb = (c - 1) / 2;
            ea = 14'((base[ep] >> 2) + 32'(eb));
            check($sformatf("burst_c%0d", c),
                  SRAMCS === 1'b1 && SRAMADDR === ea && SRAMWEN === 4'hF &&
                  SRAMWDATA === beat_data(ep, eb),
                  $sformatf("cs=%b addr=%h wen=%h wdata=%h want cs=1 addr=%h wen=f wdata=%h",
                            SRAMCS, SRAMADDR, SRAMWEN, SRAMWDATA, ea, beat_data(ep, eb)));
         end else begin
            check($sformatf("burst_c%0d", c), SRAMCS === 1'b0,
                  $sformatf("cs=%b want cs=0", SRAMCS));
         end
         @(posedge HCLK);
         for (int p = 0; p < 2; p++) begin
            if (rdy_s[p]) begin
               if (aph[p] < 4) begin
                  dph[p] = aph[p];
                  aph[p] = aph[p] + 1;
               end else begin
                  dph[p] = -1;
               end
            end
         end
         #1;
         drive_burst();
      end
      check("burst_mem_last", mem[14'hC3] === beat_data(1, 3),
            $sformatf("mem[c3]=%h want %h", mem[14'hC3], beat_data(1, 3)));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
